axilite_slave_resp: RTL and testbench

- Parametrised successor of the AXI-Lite slave front end in the axilite_axis user block.
- Converts AXI-Lite slave transactions into single-cycle backend strobes, with a configurable address and data width.
- Adds a full write-response (B) channel and accepts AW and W independently in any order.
- Adds backend write-completion handshake, a per-transaction timeout that returns SLVERR, and RRESP/BRESP reporting. Read and write paths run concurrently.

---
 rtl/axil_pkg.sv | 10 +
 rtl/axil_bk_timer.sv | 31 +++
 rtl/axilite_slave_resp.sv | 196 +++++++++++++++++++
 tb/tb_axilite_slave_resp.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
// Shared AXI-Lite response codes and front-end FSM state types.
package axil_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_BK, W_WAIT, W_RESP} wr_state_t;
   typedef enum logic [1:0] {R_IDLE, R_BK, R_WAIT, R_RESP} rd_state_t;

endpackage

// File: rtl/axil_bk_timer.sv
// Backend completion watchdog: counts enabled cycles and flags the cycle the
// count reaches TIMEOUT_CYC. TIMEOUT_CYC = 0 never expires.
module axil_bk_timer #(
   parameter int unsigned TIMEOUT_CYC = 256,
   parameter int unsigned CNT_W       = $clog2(TIMEOUT_CYC + 1)
) (
   input  logic axi_aclk,
   input  logic axi_aresetn,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int unsigned W = (CNT_W < 1) ? 1 : CNT_W;
   localparam logic [W-1:0] LAST = (TIMEOUT_CYC == 0) ? '0 : W'(TIMEOUT_CYC - 1);

   logic [W-1:0] cnt;

   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (en)
         cnt <= cnt + W'(1);
   end

   // cnt holds completed cycles, so the Nth enabled cycle sees N-1
   assign expired = (TIMEOUT_CYC != 0) && en && (cnt == LAST);

endmodule

// File: rtl/axilite_slave_resp.sv
// AXI-Lite slave front end: independent AW/W capture, single-cycle backend
// strobes, completion handshake with timeout, and B/R responses.
module axilite_slave_resp
   import axil_pkg::*;
#(
   parameter int unsigned ADDR_W      = 15,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned TIMEOUT_CYC = 256,
   parameter int unsigned CNT_W       = $clog2(TIMEOUT_CYC + 1)
) (
   input  logic                axi_aclk,
   input  logic                axi_aresetn,
   input  logic                axi_awvalid,
   output logic                axi_awready,
   input  logic [ADDR_W-1:0]   axi_awaddr,
   input  logic                axi_wvalid,
   output logic                axi_wready,
   input  logic [DATA_W-1:0]   axi_wdata,
   input  logic [DATA_W/8-1:0] axi_wstrb,
   output logic                axi_bvalid,
   input  logic                axi_bready,
   output logic [1:0]          axi_bresp,
   input  logic                axi_arvalid,
   output logic                axi_arready,
   input  logic [ADDR_W-1:0]   axi_araddr,
   output logic                axi_rvalid,
   input  logic                axi_rready,
   output logic [DATA_W-1:0]   axi_rdata,
   output logic [1:0]          axi_rresp,
   output logic                bk_wstart,
   output logic [ADDR_W-1:0]   bk_waddr,
   output logic [DATA_W-1:0]   bk_wdata,
   output logic [DATA_W/8-1:0] bk_wstrb,
   input  logic                bk_wdone,
   output logic                bk_rstart,
   output logic [ADDR_W-1:0]   bk_raddr,
   input  logic [DATA_W-1:0]   bk_rdata,
   input  logic                bk_rdone,
   input  logic                cc_aa_enable
);

   wr_state_t           wr_state;
   rd_state_t           rd_state;
   logic                aw_held, w_held;
   logic [ADDR_W-1:0]   awaddr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W/8-1:0] wstrb_q;
   logic                aw_hs, w_hs, ar_hs;
   logic                wr_expired, rd_expired;

   // readies are gated by reset so every output reads 0 while held in reset
   assign axi_awready = axi_aresetn & cc_aa_enable & (wr_state == W_IDLE) & ~aw_held;
   assign axi_wready  = axi_aresetn & cc_aa_enable & (wr_state == W_IDLE) & ~w_held;
   assign axi_arready = axi_aresetn & cc_aa_enable & (rd_state == R_IDLE);

   assign aw_hs = axi_awvalid & axi_awready;
   assign w_hs  = axi_wvalid & axi_wready;
   assign ar_hs = axi_arvalid & axi_arready;

   axil_bk_timer #(.TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(CNT_W)) u_wr_timer (
      .axi_aclk   (axi_aclk),
      .axi_aresetn(axi_aresetn),
      .clr        (wr_state == W_BK),
      .en         (wr_state == W_WAIT),
      .expired    (wr_expired)
   );

   axil_bk_timer #(.TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(CNT_W)) u_rd_timer (
      .axi_aclk   (axi_aclk),
      .axi_aresetn(axi_aresetn),
      .clr        (rd_state == R_BK),
      .en         (rd_state == R_WAIT),
      .expired    (rd_expired)
   );

   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         wr_state   <= W_IDLE;
         aw_held    <= 1'b0;
         w_held     <= 1'b0;
         awaddr_q   <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         bk_wstart  <= 1'b0;
         bk_waddr   <= '0;
         bk_wdata   <= '0;
         bk_wstrb   <= '0;
         axi_bvalid <= 1'b0;
         axi_bresp  <= RESP_OKAY;
      end else begin
         case (wr_state)
            W_IDLE: begin
               if (aw_hs) begin
                  aw_held  <= 1'b1;
                  awaddr_q <= axi_awaddr;
               end
               if (w_hs) begin
                  w_held  <= 1'b1;
                  wdata_q <= axi_wdata;
                  wstrb_q <= axi_wstrb;
               end
               // bypass the holding regs so the strobe follows the last handshake by one cycle
               if ((aw_held | aw_hs) && (w_held | w_hs)) begin
                  wr_state  <= W_BK;
                  bk_wstart <= 1'b1;
                  bk_waddr  <= aw_hs ? axi_awaddr : awaddr_q;
                  bk_wdata  <= w_hs ? axi_wdata : wdata_q;
                  bk_wstrb  <= w_hs ? axi_wstrb : wstrb_q;
               end
            end
            W_BK: begin
               bk_wstart <= 1'b0;
               bk_waddr  <= '0;
               bk_wdata  <= '0;
               bk_wstrb  <= '0;
               if (bk_wdone) begin
                  wr_state   <= W_RESP;
                  axi_bvalid <= 1'b1;
                  axi_bresp  <= RESP_OKAY;
               end else begin
                  wr_state <= W_WAIT;
               end
            end
            W_WAIT: begin
               if (bk_wdone) begin
                  wr_state   <= W_RESP;
                  axi_bvalid <= 1'b1;
                  axi_bresp  <= RESP_OKAY;
               end else if (wr_expired) begin
                  wr_state   <= W_RESP;
                  axi_bvalid <= 1'b1;
                  axi_bresp  <= RESP_SLVERR;
               end
            end
            W_RESP: begin
               if (axi_bready) begin
                  wr_state   <= W_IDLE;
                  axi_bvalid <= 1'b0;
                  axi_bresp  <= RESP_OKAY;
                  aw_held    <= 1'b0;
                  w_held     <= 1'b0;
               end
            end
            default: wr_state <= W_IDLE;
         endcase
      end
   end

   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         rd_state   <= R_IDLE;
         bk_rstart  <= 1'b0;
         bk_raddr   <= '0;
         axi_rvalid <= 1'b0;
         axi_rdata  <= '0;
         axi_rresp  <= RESP_OKAY;
      end else begin
         case (rd_state)
            R_IDLE: begin
               if (ar_hs) begin
                  rd_state  <= R_BK;
                  bk_rstart <= 1'b1;
                  bk_raddr  <= axi_araddr;
               end
            end
            R_BK, R_WAIT: begin
               bk_rstart <= 1'b0;
               bk_raddr  <= '0;
               if (bk_rdone) begin
                  rd_state   <= R_RESP;
                  axi_rvalid <= 1'b1;
                  axi_rdata  <= bk_rdata;
                  axi_rresp  <= RESP_OKAY;
               end else if (rd_state == R_BK) begin
                  rd_state <= R_WAIT;
               end else if (rd_expired) begin
                  rd_state   <= R_RESP;
                  axi_rvalid <= 1'b1;
                  axi_rdata  <= '0;
                  axi_rresp  <= RESP_SLVERR;
               end
            end
            R_RESP: begin
               if (axi_rready) begin
                  rd_state   <= R_IDLE;
                  axi_rvalid <= 1'b0;
                  axi_rdata  <= '0;
                  axi_rresp  <= RESP_OKAY;
               end
            end
            default: rd_state <= R_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axilite_slave_resp.sv
// Directed and randomized transactions checked against cycle-count expectations
// derived from the handshake/latency/timeout rules.
module tb_axilite_slave_resp;

   localparam int AW = 15;
   localparam int DW = 32;
   localparam int SW = DW / 8;
   localparam int TO = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n, en;
   logic          awvalid, wvalid, bready, arvalid, rready, bk_wdone, bk_rdone;
   logic [AW-1:0] awaddr, araddr;
   logic [DW-1:0] wdata, bk_rdata;
   logic [SW-1:0] wstrb;
   logic          awready, wready, bvalid, arready, rvalid, bk_wstart, bk_rstart;
   logic [1:0]    bresp, rresp;
   logic [DW-1:0] rdata, bk_wdata;
   logic [AW-1:0] bk_waddr, bk_raddr;
   logic [SW-1:0] bk_wstrb;

   int n_cmp = 0;
   int n_err = 0;

   axilite_slave_resp #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
      .axi_aclk(clk), .axi_aresetn(rst_n),
      .axi_awvalid(awvalid), .axi_awready(awready), .axi_awaddr(awaddr),
      .axi_wvalid(wvalid), .axi_wready(wready), .axi_wdata(wdata), .axi_wstrb(wstrb),
      .axi_bvalid(bvalid), .axi_bready(bready), .axi_bresp(bresp),
      .axi_arvalid(arvalid), .axi_arready(arready), .axi_araddr(araddr),
      .axi_rvalid(rvalid), .axi_rready(rready), .axi_rdata(rdata), .axi_rresp(rresp),
      .bk_wstart(bk_wstart), .bk_waddr(bk_waddr), .bk_wdata(bk_wdata), .bk_wstrb(bk_wstrb),
      .bk_wdone(bk_wdone), .bk_rstart(bk_rstart), .bk_raddr(bk_raddr),
      .bk_rdata(bk_rdata), .bk_rdone(bk_rdone), .cc_aa_enable(en)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] all_outputs();
      return 128'({awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp,
                   bk_wstart, bk_waddr, bk_wdata, bk_wstrb, bk_rstart, bk_raddr});
   endfunction

   // done_d: cycles after bk_wstart that bk_wdone pulses (<0: never)
   task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s,
                           input int aw_d, input int w_d, input int done_d, input int br_d);
      int cyc = 0, aw_c = -1, w_c = -1, nstart = 0, exp_k, k;
      logic [1:0] exp_resp;
      awaddr = a; wdata = d; wstrb = s;
      while ((aw_c < 0 || w_c < 0) && cyc < 200) begin
         awvalid = (aw_c < 0) && (cyc >= aw_d);
         wvalid  = (w_c < 0) && (cyc >= w_d);
         @(negedge clk);
         chk("awready", awready, aw_c < 0);
         chk("wready", wready, w_c < 0);
         if (awvalid && awready) aw_c = cyc;
         if (wvalid && wready) w_c = cyc;
         nstart += int'(bk_wstart);
         @(posedge clk); #1; cyc++;
      end
      awvalid = 1'b0; wvalid = 1'b0;
      chk("aw_w_accepted", 128'(aw_c >= 0 && w_c >= 0), 1);
      bk_wdone = (done_d == 0);
      @(negedge clk);
      chk("bk_wstart", bk_wstart, 1);
      chk("bk_waddr", bk_waddr, a);
      chk("bk_wdata", bk_wdata, d);
      chk("bk_wstrb", bk_wstrb, s);
      nstart += int'(bk_wstart);
      @(posedge clk); #1;
      exp_k    = (done_d >= 0 && done_d <= TO) ? done_d + 1 : TO + 1;
      exp_resp = (done_d >= 0 && done_d <= TO) ? 2'b00 : 2'b10;
      for (k = 1; k < exp_k; k++) begin
         bk_wdone = (k == done_d);
         @(negedge clk);
         chk("bvalid_early", bvalid, 0);
         nstart += int'(bk_wstart);
         @(posedge clk); #1;
      end
      for (int j = 0; j <= br_d; j++) begin
         bk_wdone = (k == done_d);
         bready = (j == br_d);
         @(negedge clk);
         chk("bvalid", bvalid, 1);
         chk("bresp", bresp, exp_resp);
         nstart += int'(bk_wstart);
         @(posedge clk); #1; k++;
      end
      bready = 1'b0; bk_wdone = 1'b0;
      @(negedge clk);
      chk("bvalid_after", bvalid, 0);
      chk("wstart_count", nstart, 1);
      @(posedge clk); #1;
   endtask

   task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] rd,
                          input int ar_d, input int done_d, input int rr_d);
      int cyc = 0, ar_c = -1, nstart = 0, exp_k, k;
      logic ok;
      araddr = a;
      while (ar_c < 0 && cyc < 200) begin
         arvalid = (cyc >= ar_d);
         @(negedge clk);
         chk("arready", arready, 1);
         if (arvalid && arready) ar_c = cyc;
         nstart += int'(bk_rstart);
         @(posedge clk); #1; cyc++;
      end
      arvalid = 1'b0;
      chk("ar_accepted", 128'(ar_c >= 0), 1);
      bk_rdone = (done_d == 0);
      bk_rdata = (done_d == 0) ? rd : $urandom;
      @(negedge clk);
      chk("bk_rstart", bk_rstart, 1);
      chk("bk_raddr", bk_raddr, a);
      nstart += int'(bk_rstart);
      @(posedge clk); #1;
      ok    = (done_d >= 0 && done_d <= TO);
      exp_k = ok ? done_d + 1 : TO + 1;
      for (k = 1; k < exp_k; k++) begin
         bk_rdone = (k == done_d);
         bk_rdata = (k == done_d) ? rd : $urandom;
         @(negedge clk);
         chk("rvalid_early", rvalid, 0);
         nstart += int'(bk_rstart);
         @(posedge clk); #1;
      end
      for (int j = 0; j <= rr_d; j++) begin
         bk_rdone = (k == done_d);
         bk_rdata = $urandom;
         rready = (j == rr_d);
         @(negedge clk);
         chk("rvalid", rvalid, 1);
         chk("rresp", rresp, ok ? 2'b00 : 2'b10);
         chk("rdata", rdata, ok ? rd : '0);
         nstart += int'(bk_rstart);
         @(posedge clk); #1; k++;
      end
      rready = 1'b0; bk_rdone = 1'b0;
      @(negedge clk);
      chk("rvalid_after", rvalid, 0);
      chk("rstart_count", nstart, 1);
      @(posedge clk); #1;
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b1;
      awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
      bk_wdone = 0; bk_rdone = 0; awaddr = '0; araddr = '0; wdata = '0; wstrb = '0; bk_rdata = '0;
      #3;
      chk("reset_outputs", all_outputs(), '0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      do_write(15'h1004, 32'hDEADBEEF, 4'hF, 0, 3, 2, 0);
      do_write(15'h2222, 32'h01020304, 4'h5, 3, 0, 1, 0);
      do_write(15'h3333, 32'hA0B0C0D0, 4'hA, 0, 0, 0, 5);
      do_write(15'h0100, 32'h11111111, 4'h1, 0, 0, TO, 1);
      do_write(15'h0200, 32'h22222222, 4'h2, 0, 0, -1, 2);

      do_read(15'h0040, 32'h12345678, 0, 3, 4);
      do_read(15'h0044, 32'h0, 0, -1, 0);
      bk_rdone = 1'b1; bk_rdata = 32'hBAD0BAD0;
      @(negedge clk);
      chk("stale_rstart", bk_rstart, 0);
      @(posedge clk); #1; bk_rdone = 1'b0;
      @(negedge clk);
      chk("stale_rvalid", rvalid, 0);
      @(posedge clk); #1;
      do_read(15'h0048, 32'h9ABCDEF0, 1, 0, 0);

      en = 1'b0; awvalid = 1; wvalid = 1; arvalid = 1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("gated", 128'({awready, wready, arready, bk_wstart, bk_rstart}), '0);
         @(posedge clk); #1;
      end
      en = 1'b1;
      fork
         do_write(15'h0ABC, 32'hFEEDFACE, 4'hC, 0, 0, 1, 0);
         do_read(15'h0DEF, 32'h55AA55AA, 0, 2, 1);
      join

      awaddr = 15'h0123; wdata = 32'hCAFEF00D; wstrb = 4'h3; araddr = 15'h0456;
      awvalid = 1; wvalid = 1; arvalid = 1;
      @(negedge clk);
      chk("rst_tc_readies", 128'({awready, wready, arready}), 3'b111);
      @(posedge clk); #1; awvalid = 0; wvalid = 0; arvalid = 0;
      @(negedge clk);
      chk("rst_tc_starts", 128'({bk_wstart, bk_rstart}), 2'b11);
      bk_rdone = 1'b1; bk_rdata = 32'hA5A55A5A;
      @(posedge clk); #1; bk_rdone = 1'b0;
      @(negedge clk);
      chk("rst_tc_valids", 128'({bvalid, rvalid}), 2'b01);
      chk("rst_tc_rdata", rdata, 32'hA5A55A5A);
      #1 rst_n = 1'b0;
      #1 chk("async_reset", all_outputs(), '0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("held_reset", all_outputs(), '0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      fork
         do_write(15'h0777, 32'h76543210, 4'hF, 1, 0, 2, 1);
         do_read(15'h0888, 32'h0F0F0F0F, 0, 1, 0);
      join

      for (int i = 0; i < 8; i++) begin
         logic [AW-1:0] wa, ra;
         logic [DW-1:0] wd, rd;
         logic [SW-1:0] ws;
         int awd, wd_d, wdn, brd, ard, rdn, rrd;
         wa = AW'($urandom); ra = AW'($urandom); wd = $urandom; rd = $urandom; ws = SW'($urandom);
         awd = $urandom_range(0, 3); wd_d = $urandom_range(0, 3); wdn = $urandom_range(0, 20);
         brd = $urandom_range(0, 3); ard = $urandom_range(0, 3); rdn = $urandom_range(0, 20);
         rrd = $urandom_range(0, 3);
         fork
            do_write(wa, wd, ws, awd, wd_d, wdn, brd);
            do_read(ra, rd, ard, rdn, rrd);
         join
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
